// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared APB types and default bus widths (requester/completer).
// Revision    : 1.0
// ============================================================================
package apb_pkg;

    localparam int c_apb_addrwidth = 8;
    localparam int c_apb_datawidth = 32;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_requester_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_requester_if
// Description : Command/response stream plus APB3 bus seen by the requester.
// Revision    : 1.0
// ============================================================================
interface apb_requester_if
    import apb_pkg::*;
#(
    parameter int ADDRWIDTH = c_apb_addrwidth,
    parameter int DATAWIDTH = c_apb_datawidth
) ();

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDRWIDTH-1:0] cmd_addr;
    logic [DATAWIDTH-1:0] cmd_wdata;
    logic                 rsp_valid;
    logic [DATAWIDTH-1:0] rsp_rdata;
    logic                 rsp_err;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADDRWIDTH-1:0] paddr;
    logic [DATAWIDTH-1:0] pwdata;
    logic [DATAWIDTH-1:0] prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );

endinterface
`default_nettype wire

// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
// Module      : apb_requester
// Description : APB3 requester turning a valid/ready command stream into
//               SETUP/ACCESS transfers, with a wait-state watchdog.
// Revision    : 1.0
// ============================================================================
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDRWIDTH = c_apb_addrwidth,
    parameter int DATAWIDTH = c_apb_datawidth,
    parameter int TIMEOUT   = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    apb_requester_if.master bus
);

    localparam int                 c_cnt_w    = $clog2(TIMEOUT) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;

    apb_state_t           r_state,     w_state_nxt;
    logic                 r_psel,      w_psel_nxt;
    logic                 r_penable,   w_pen_nxt;
    logic                 r_pwrite,    w_pwrite_nxt;
    logic [ADDRWIDTH-1:0] r_paddr,     w_paddr_nxt;
    logic [DATAWIDTH-1:0] r_pwdata,    w_pwdata_nxt;
    logic [c_cnt_w-1:0]   r_cnt,       w_cnt_nxt;
    logic                 r_rsp_valid, w_rv_nxt;
    logic                 r_rsp_err,   w_rerr_nxt;
    logic [DATAWIDTH-1:0] r_rsp_rdata, w_rdata_nxt;
    logic                 w_cmd_ready;

    // Ready is combinational from pready so a completing transfer can hand
    // straight over to the next command without an IDLE gap.
    assign w_cmd_ready = (r_state == APB_IDLE) || ((r_state == APB_ACCESS) && bus.pready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= APB_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_pen_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_valid <= w_rv_nxt;
            r_rsp_err   <= w_rerr_nxt;
            r_rsp_rdata <= w_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_psel_nxt   = r_psel;
        w_pen_nxt    = r_penable;
        w_pwrite_nxt = r_pwrite;
        w_paddr_nxt  = r_paddr;
        w_pwdata_nxt = r_pwdata;
        w_cnt_nxt    = r_cnt;
        w_rv_nxt     = 1'b0;
        w_rerr_nxt   = 1'b0;
        w_rdata_nxt  = r_rsp_rdata;
        case (r_state)
            APB_IDLE: begin
                if (bus.cmd_valid) begin
                    w_pwrite_nxt = bus.cmd_write;
                    w_paddr_nxt  = bus.cmd_addr;
                    w_pwdata_nxt = bus.cmd_wdata;
                    w_psel_nxt   = 1'b1;
                    w_pen_nxt    = 1'b0;
                    w_state_nxt  = APB_SETUP;
                end
            end
            APB_SETUP: begin
                w_pen_nxt   = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (bus.pready) begin
                    w_rv_nxt    = 1'b1;
                    w_rerr_nxt  = bus.pslverr;
                    w_rdata_nxt = r_pwrite ? '0 : bus.prdata;
                    w_pen_nxt   = 1'b0;
                    if (bus.cmd_valid) begin
                        w_pwrite_nxt = bus.cmd_write;
                        w_paddr_nxt  = bus.cmd_addr;
                        w_pwdata_nxt = bus.cmd_wdata;
                        w_state_nxt  = APB_SETUP;
                    end else begin
                        w_psel_nxt  = 1'b0;
                        w_state_nxt = APB_IDLE;
                    end
                end else if (r_cnt >= c_cnt_last) begin
                    // Watchdog abort: report an error with no data.
                    w_psel_nxt  = 1'b0;
                    w_pen_nxt   = 1'b0;
                    w_rv_nxt    = 1'b1;
                    w_rerr_nxt  = 1'b1;
                    w_rdata_nxt = '0;
                    w_state_nxt = APB_IDLE;
                end else if (r_cnt != c_cnt_max) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_psel_nxt  = 1'b0;
                w_pen_nxt   = 1'b0;
                w_state_nxt = APB_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_requester
// Description : Directed bench for apb_requester with a behavioural completer
//               and a transaction-level response/bus-timing model.
// Revision    : 1.0
// ============================================================================
module tb_apb_requester;
    import apb_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int TO    = 16;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    int   waits_cfg = 0;
    logic err_cfg   = 1'b0;
    int   acc_n;
    logic [DW-1:0] mem [0:255];

    apb_requester_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bif ();

    apb_requester #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Completer: answers after waits_cfg wait states, flags error when err_cfg.
    always @(posedge clk or negedge rst) begin
        if (!rst)                                         acc_n <= 0;
        else if (bif.psel && bif.penable && !bif.pready) acc_n <= acc_n + 1;
        else                                              acc_n <= 0;
    end
    always @(posedge clk)
        if (rst && bif.psel && bif.penable && bif.pready && bif.pwrite && !err_cfg)
            mem[bif.paddr] <= bif.pwdata;
    assign bif.pready  = bif.psel && bif.penable && (acc_n >= waits_cfg);
    assign bif.pslverr = bif.pready && err_cfg;
    assign bif.prdata  = mem[bif.paddr];

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Transaction model: each accepted command owns the bus from acc+1 to
    // due-1 and answers at due = acc + 3 + wait states (capped by the watchdog).
    typedef struct {
        int            acc;
        int            due;
        logic          wr;
        logic          to;
        logic          err;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;
    exp_t q[$];
    logic [DW-1:0] shadow [int];

    always @(negedge clk) begin : p_cmp
        logic          ps_e, pe_e, rv_e, w_e;
        logic [AW-1:0] a_e;
        logic [DW-1:0] d_e, rd_e;
        exp_t          e;
        ps_e = 1'b0; pe_e = 1'b0; rv_e = 1'b0; w_e = 1'b0; a_e = '0; d_e = '0; rd_e = '0;
        if (!rst) begin
            q.delete();
        end else begin
            foreach (q[i]) begin
                if (cyc > q[i].acc && cyc < q[i].due) begin
                    ps_e = 1'b1;
                    pe_e = (cyc > q[i].acc + 1);
                    a_e  = q[i].addr;
                    w_e  = q[i].wr;
                    d_e  = q[i].wdata;
                end
            end
            rv_e = (q.size() > 0) && (q[0].due == cyc);
        end
        chk("psel", longint'(bif.psel), longint'(ps_e));
        chk("penable", longint'(bif.penable), longint'(pe_e));
        chk("rsp_valid", longint'(bif.rsp_valid), longint'(rv_e));
        if (ps_e) begin
            chk("paddr", longint'(bif.paddr), longint'(a_e));
            chk("pwrite", longint'(bif.pwrite), longint'(w_e));
            if (w_e) chk("pwdata", longint'(bif.pwdata), longint'(d_e));
        end
        if (rv_e) begin
            e = q.pop_front();
            if (!e.wr && !e.to && shadow.exists(int'(e.addr))) rd_e = shadow[int'(e.addr)];
            chk("rsp_rdata", longint'(bif.rsp_rdata), longint'(rd_e));
            chk("rsp_err", longint'(bif.rsp_err), longint'(e.err));
            if (e.wr && !e.err) shadow[int'(e.addr)] = e.wdata;
        end
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        if (rst && bif.cmd_valid && bif.cmd_ready) begin
            e.acc   = cyc;
            e.wr    = bif.cmd_write;
            e.addr  = bif.cmd_addr;
            e.wdata = bif.cmd_wdata;
            e.to    = (waits_cfg >= TO);
            e.due   = cyc + 3 + (e.to ? TO - 1 : waits_cfg);
            e.err   = e.to || err_cfg;
            q.push_back(e);
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int l_ps, output int l_pe, output int l_rsp, output int n_acc,
                         output logic [DW-1:0] rd, output logic er);
        int c0;
        bit got;
        l_ps = -1; l_pe = -1; l_rsp = -1; n_acc = 0; rd = '0; er = 1'b0; c0 = 0;
        @(posedge clk); #1;
        bif.cmd_valid = 1'b1; bif.cmd_write = wr; bif.cmd_addr = a; bif.cmd_wdata = d;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bif.cmd_ready) begin got = 1'b1; c0 = cyc; end
        end
        @(posedge clk); #1;
        bif.cmd_valid = 1'b0;
        chk("cmd_accepted", longint'(got), 1);
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (bif.psel && l_ps < 0)    l_ps = cyc - c0;
            if (bif.penable && l_pe < 0) l_pe = cyc - c0;
            if (bif.psel && bif.penable) n_acc++;
            if (bif.rsp_valid) begin
                got = 1'b1; l_rsp = cyc - c0; rd = bif.rsp_rdata; er = bif.rsp_err;
            end
        end
        chk("rsp_seen", longint'(got), 1);
    endtask

    initial begin : p_watchdog
        #100000;
        $display("FAIL watchdog: time actual=%0t required<100000", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : p_main
        int            lps, lpe, lrsp, nacc, pscnt, rcnt, rises, idx;
        logic [DW-1:0] rd;
        logic          er, prev_ps, acc_now;
        bit            got;
        bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_addr = '0; bif.cmd_wdata = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pwrite", longint'(bif.pwrite), 0);
        chk("reset_paddr", longint'(bif.paddr), 0);
        chk("reset_pwdata", longint'(bif.pwdata), 0);
        chk("reset_rsp_rdata", longint'(bif.rsp_rdata), 0);
        chk("reset_rsp_err", longint'(bif.rsp_err), 0);
        @(posedge clk); #1 rst = 1'b1;

        // Zero-wait write.
        issue(1'b1, 8'h10, 32'hDEADBEEF, lps, lpe, lrsp, nacc, rd, er);
        chk("wr_lat_psel", lps, 1);
        chk("wr_lat_penable", lpe, 2);
        chk("wr_lat_rsp", lrsp, 3);
        chk("wr_err", longint'(er), 0);
        chk("wr_rdata", longint'(rd), 0);

        // Read with three wait states.
        waits_cfg = 3;
        issue(1'b0, 8'h10, 32'h0, lps, lpe, lrsp, nacc, rd, er);
        chk("rd_lat_rsp", lrsp, 6);
        chk("rd_access_cycles", nacc, 4);
        chk("rd_rdata", longint'(rd), 64'hDEADBEEF);
        chk("rd_err", longint'(er), 0);
        waits_cfg = 0;

        // Four back-to-back writes with cmd_valid held.
        @(posedge clk); #1;
        idx = 0; pscnt = 0; rcnt = 0; rises = 0; prev_ps = 1'b0;
        bif.cmd_valid = 1'b1; bif.cmd_write = 1'b1; bif.cmd_addr = '0; bif.cmd_wdata = 32'h1000_0000;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bif.psel) pscnt++;
            if (bif.psel && !prev_ps) rises++;
            prev_ps = bif.psel;
            if (bif.rsp_valid) rcnt++;
            acc_now = bif.cmd_valid && bif.cmd_ready;
            @(posedge clk); #1;
            if (acc_now) begin
                idx++;
                if (idx == 4) bif.cmd_valid = 1'b0;
                else begin
                    bif.cmd_addr  = AW'(idx);
                    bif.cmd_wdata = 32'h1000_0000 + DW'(idx);
                end
            end
        end
        chk("b2b_psel_cycles", pscnt, 8);
        chk("b2b_psel_rises", rises, 1);
        chk("b2b_rsp_pulses", rcnt, 4);
        chk("b2b_accepted", idx, 4);
        issue(1'b0, 8'h02, 32'h0, lps, lpe, lrsp, nacc, rd, er);
        chk("b2b_readback", longint'(rd), 64'h1000_0002);

        // Completer never answers: watchdog abort.
        waits_cfg = NEVER;
        issue(1'b0, 8'h20, 32'h0, lps, lpe, lrsp, nacc, rd, er);
        chk("to_access_cycles", nacc, 16);
        chk("to_lat_rsp", lrsp, 18);
        chk("to_err", longint'(er), 1);
        chk("to_rdata", longint'(rd), 0);
        waits_cfg = 0;

        // Slave error on a read of the top address.
        issue(1'b1, 8'hFF, 32'h5A5A_0000, lps, lpe, lrsp, nacc, rd, er);
        err_cfg = 1'b1;
        issue(1'b0, 8'hFF, 32'h0, lps, lpe, lrsp, nacc, rd, er);
        chk("slverr_err", longint'(er), 1);
        chk("slverr_lat_rsp", lrsp, 3);
        chk("slverr_rdata", longint'(rd), 64'h5A5A_0000);
        @(negedge clk);
        chk("slverr_pulse_width", longint'(bif.rsp_valid), 0);
        err_cfg = 1'b0;

        // Reset during an ACCESS wait state.
        waits_cfg = 5;
        @(posedge clk); #1;
        bif.cmd_valid = 1'b1; bif.cmd_write = 1'b0; bif.cmd_addr = 8'h10; bif.cmd_wdata = '0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = bif.cmd_ready;
        end
        @(posedge clk); #1;
        bif.cmd_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = bif.psel && bif.penable;
        end
        chk("rstmid_reached_access", longint'(got), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstmid_psel", longint'(bif.psel), 0);
        chk("rstmid_penable", longint'(bif.penable), 0);
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_no_rsp", longint'(bif.rsp_valid), 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        waits_cfg = 0;
        issue(1'b0, 8'h10, 32'h0, lps, lpe, lrsp, nacc, rd, er);
        chk("post_rst_rdata", longint'(rd), 64'hDEADBEEF);
        chk("post_rst_lat_rsp", lrsp, 3);
        chk("post_rst_err", longint'(er), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
